writeback_arbiter: RTL and testbench

Merges register writes from the single-cycle ALU path and the variable-latency memory-load path onto the register file's single write port (`data_in`, `address`, `write`). It buffers load results in a small FIFO whenever the ALU owns the port, and drives registered write-port outputs. It also reports per-register pending-write hazards to decode so that no two in-flight writes to the same register can reorder. It sits directly upstream of the 32 x 64 register file.

---
 rtl/datapath_defs_pkg.sv | 17 +
 rtl/writeback_fifo.sv | 86 ++++++++
 rtl/writeback_arbiter.sv | 133 +++++++++++++
 tb/tb_writeback_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_defs_pkg.sv
// ============================================================================
// Module   : datapath_defs
// Purpose  : Register-file constants shared by the writeback path and the
//            register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package datapath_defs;

    localparam int ZERO_REG       = 31;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 64;

endpackage

`default_nettype wire

// File: rtl/writeback_fifo.sv
// ============================================================================
// Module   : writeback_fifo
// Purpose  : Synchronous load-result FIFO. Exposes every entry address and
//            valid bit so the parent can run a pending-write compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                push,
    input  logic [ADDR_WIDTH-1:0]               push_address,
    input  logic [DATA_WIDTH-1:0]               push_data,
    input  logic                                pop,
    output logic [ADDR_WIDTH-1:0]               head_address,
    output logic [DATA_WIDTH-1:0]               head_data,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(DEPTH):0]              count,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]    entry_address,
    output logic [DEPTH-1:0]                    entry_valid
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
    logic [DEPTH-1:0]                 r_valid;
    logic [PTR_WIDTH-1:0]             r_wr_ptr;
    logic [PTR_WIDTH-1:0]             r_rd_ptr;
    logic [CNT_WIDTH-1:0]             r_count;
    logic                             w_do_push;
    logic                             w_do_pop;

    assign full          = (r_count == CNT_WIDTH'(DEPTH));
    assign empty         = (r_count == '0);
    assign count         = r_count;
    assign head_address  = r_addr[r_rd_ptr];
    assign head_data     = r_data[r_rd_ptr];
    assign entry_address = r_addr;
    assign entry_valid   = r_valid;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            // Pop and push never target the same slot: pop needs non-empty,
            // push needs non-full, so equal pointers cannot coincide here.
            if (w_do_pop) begin
                r_rd_ptr          <= r_rd_ptr + PTR_WIDTH'(1);
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_do_push) begin
                r_wr_ptr          <= r_wr_ptr + PTR_WIDTH'(1);
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_addr[r_wr_ptr] <= push_address;
            r_data[r_wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Merges ALU and load writebacks onto the single register-file
//            write port and reports pending-write hazards to decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_arbiter
    import datapath_defs::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_address,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_data,
    input  logic [ADDR_WIDTH-1:0] query_a,
    input  logic [ADDR_WIDTH-1:0] query_b,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic [2:0]            pending
);

    localparam logic [ADDR_WIDTH-1:0] c_zero_reg = ADDR_WIDTH'(ZERO_REG);

    logic                             w_full;
    logic                             w_empty;
    logic [$clog2(DEPTH):0]           w_count;
    logic [ADDR_WIDTH-1:0]            w_head_address;
    logic [DATA_WIDTH-1:0]            w_head_data;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] w_entry_address;
    logic [DEPTH-1:0]                 w_entry_valid;
    logic                             w_alu_live;
    logic                             w_mem_live;
    logic                             w_pop;
    logic                             w_bypass;
    logic                             w_push;

    logic                             r_rf_write;
    logic [ADDR_WIDTH-1:0]            r_rf_address;
    logic [DATA_WIDTH-1:0]            r_rf_data;

    assign mem_ready  = !w_full;
    assign w_alu_live = alu_valid && (alu_address != c_zero_reg);
    // Loads to the zero register complete the handshake and vanish.
    assign w_mem_live = mem_valid && mem_ready && (mem_address != c_zero_reg);
    assign w_pop      = !w_alu_live && !w_empty;
    assign w_bypass   = !w_alu_live && w_empty && w_mem_live;
    assign w_push     = w_mem_live && !w_bypass;

    writeback_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock         (clock),
        .reset         (reset),
        .push          (w_push),
        .push_address  (mem_address),
        .push_data     (mem_data),
        .pop           (w_pop),
        .head_address  (w_head_address),
        .head_data     (w_head_data),
        .full          (w_full),
        .empty         (w_empty),
        .count         (w_count),
        .entry_address (w_entry_address),
        .entry_valid   (w_entry_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rf_write   <= 1'b0;
            r_rf_address <= '0;
            r_rf_data    <= '0;
        end else if (w_alu_live) begin
            r_rf_write   <= 1'b1;
            r_rf_address <= alu_address;
            r_rf_data    <= alu_data;
        end else if (w_pop) begin
            r_rf_write   <= 1'b1;
            r_rf_address <= w_head_address;
            r_rf_data    <= w_head_data;
        end else if (w_bypass) begin
            r_rf_write   <= 1'b1;
            r_rf_address <= mem_address;
            r_rf_data    <= mem_data;
        end else begin
            r_rf_write   <= 1'b0;
        end
    end

    assign rf_write   = r_rf_write;
    assign rf_address = r_rf_address;
    assign rf_data    = r_rf_data;
    assign pending    = 3'(w_count);

    // The output stage counts as pending: the register file only captures it
    // on the next edge, so a read this cycle would still return stale data.
    function automatic logic hazard_of(
        input logic [ADDR_WIDTH-1:0]            q,
        input logic [DEPTH-1:0]                 valid,
        input logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs,
        input logic                             wr,
        input logic [ADDR_WIDTH-1:0]            wr_addr
    );
        logic hit;
        hit = wr && (wr_addr == q);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addrs[i] == q)) begin
                hit = 1'b1;
            end
        end
        return hit && (q != c_zero_reg);
    endfunction

    assign hazard_a = hazard_of(query_a, w_entry_valid, w_entry_address, r_rf_write, r_rf_address);
    assign hazard_b = hazard_of(query_b, w_entry_valid, w_entry_address, r_rf_write, r_rf_address);

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
// Module   : tb_writeback_arbiter
// Purpose  : Self-checking bench for writeback_arbiter with a queue-based
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid;
    logic [AW-1:0] alu_address;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          rf_write;
    logic [AW-1:0] rf_address;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] query_a;
    logic [AW-1:0] query_b;
    logic          hazard_a;
    logic          hazard_b;
    logic [2:0]    pending;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of waiting loads plus the last write issued.
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    writeback_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_address (alu_address),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .rf_write    (rf_write),
        .rf_address  (rf_address),
        .rf_data     (rf_data),
        .query_a     (query_a),
        .query_b     (query_b),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .pending     (pending)
    );

    always #5 clock = ~clock;

    function automatic logic model_ready();
        return q_addr.size() < DEPTH;
    endfunction

    function automatic logic model_hazard(input logic [AW-1:0] q);
        if (q == 5'd31) return 1'b0;
        foreach (q_addr[i]) if (q_addr[i] == q) return 1'b1;
        return m_write && (m_addr == q);
    endfunction

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        m_write = 1'b0;
        m_addr  = '0;
        m_data  = '0;
    endtask

    // Apply one clock of the writeback rules to the model, then advance.
    task automatic clock_edge();
        logic accepted, alu_live, mem_live, bypassed;
        accepted = mem_valid && model_ready();
        alu_live = alu_valid && (alu_address != 5'd31);
        mem_live = accepted && (mem_address != 5'd31);
        bypassed = 1'b0;
        if (alu_live) begin
            m_write = 1'b1; m_addr = alu_address; m_data = alu_data;
        end else if (q_addr.size() != 0) begin
            m_write = 1'b1; m_addr = q_addr.pop_front(); m_data = q_data.pop_front();
        end else if (mem_live) begin
            m_write = 1'b1; m_addr = mem_address; m_data = mem_data; bypassed = 1'b1;
        end else begin
            m_write = 1'b0;
        end
        if (mem_live && !bypassed) begin
            q_addr.push_back(mem_address);
            q_data.push_back(mem_data);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_address = '0; alu_data = '0;
        mem_valid = 1'b0; mem_address = '0; mem_data = '0;
    endtask

    task automatic test_reset();
        idle();
        query_a = 5'd0; query_b = 5'd0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %0h want 0", rf_write); end
        n_cmp++; if (rf_address !== 5'd0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", rf_address); end
        n_cmp++; if (rf_data !== 64'd0) begin n_bad++; $display("FAIL reset_data: got %0h want 0", rf_data); end
        n_cmp++; if (pending !== 3'd0) begin n_bad++; $display("FAIL reset_pending: got %0d want 0", pending); end
        n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0h want 1", mem_ready); end
        n_cmp++; if (hazard_a !== 1'b0) begin n_bad++; $display("FAIL reset_hazard: got %0h want 0", hazard_a); end
        reset = 1'b0;
        // Queue three loads behind ALU writes.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_address = AW'(1 + i); alu_data = {$urandom, $urandom};
            mem_valid = 1'b1; mem_address = AW'(10 + i); mem_data = {$urandom, $urandom};
            clock_edge();
            n_cmp++; if (pending !== 3'(i + 1)) begin n_bad++; $display("FAIL queue_pending: got %0d want %0d", pending, i + 1); end
        end
        idle();
        query_a = 5'd10;
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++; $display("FAIL midreset_write: got %0h want 0", rf_write); end
        n_cmp++; if (rf_address !== 5'd0) begin n_bad++; $display("FAIL midreset_addr: got %0h want 0", rf_address); end
        n_cmp++; if (rf_data !== 64'd0) begin n_bad++; $display("FAIL midreset_data: got %0h want 0", rf_data); end
        n_cmp++; if (pending !== 3'd0) begin n_bad++; $display("FAIL midreset_pending: got %0d want 0", pending); end
        n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %0h want 1", mem_ready); end
        n_cmp++; if (hazard_a !== 1'b0) begin n_bad++; $display("FAIL midreset_hazard: got %0h want 0", hazard_a); end
        @(posedge clock);
        #3 reset = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1;
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++; $display("FAIL post_reset_write: got %0h want 0", rf_write); end
        n_cmp++; if (pending !== 3'd0) begin n_bad++; $display("FAIL post_reset_pending: got %0d want 0", pending); end
    endtask

    task automatic test_alu_only();
        idle();
        alu_valid = 1'b1; alu_address = 5'd5; alu_data = 64'h1234;
        query_a = 5'd5;
        clock_edge();
        idle();
        n_cmp++; if (rf_write !== 1'b1) begin n_bad++; $display("FAIL alu_write: got %0h want 1", rf_write); end
        n_cmp++; if (rf_address !== 5'd5) begin n_bad++; $display("FAIL alu_addr: got %0d want 5", rf_address); end
        n_cmp++; if (rf_data !== 64'h1234) begin n_bad++; $display("FAIL alu_data: got %0h want 1234", rf_data); end
        n_cmp++; if (hazard_a !== 1'b1) begin n_bad++; $display("FAIL alu_hazard: got %0h want 1", hazard_a); end
        clock_edge();
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++; $display("FAIL alu_idle_write: got %0h want 0", rf_write); end
        n_cmp++; if (rf_data !== 64'h1234) begin n_bad++; $display("FAIL alu_hold_data: got %0h want 1234", rf_data); end
        n_cmp++; if (hazard_a !== 1'b0) begin n_bad++; $display("FAIL alu_hazard_clear: got %0h want 0", hazard_a); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] load_data;
        load_data = {$urandom, $urandom};
        alu_valid = 1'b1; alu_address = 5'd2; alu_data = {$urandom, $urandom};
        mem_valid = 1'b1; mem_address = 5'd3; mem_data = load_data;
        query_b = 5'd3;
        clock_edge();
        idle();
        n_cmp++; if (rf_address !== 5'd2 || rf_write !== 1'b1) begin n_bad++; $display("FAIL coll_first: got %0h/%0d want 1/2", rf_write, rf_address); end
        n_cmp++; if (pending !== 3'd1) begin n_bad++; $display("FAIL coll_pending1: got %0d want 1", pending); end
        n_cmp++; if (hazard_b !== 1'b1) begin n_bad++; $display("FAIL coll_hazard: got %0h want 1", hazard_b); end
        clock_edge();
        n_cmp++; if (rf_address !== 5'd3 || rf_write !== 1'b1) begin n_bad++; $display("FAIL coll_second: got %0h/%0d want 1/3", rf_write, rf_address); end
        n_cmp++; if (rf_data !== load_data) begin n_bad++; $display("FAIL coll_data: got %0h want %0h", rf_data, load_data); end
        n_cmp++; if (pending !== 3'd0) begin n_bad++; $display("FAIL coll_pending0: got %0d want 0", pending); end
        clock_edge();
    endtask

    task automatic test_full_fifo();
        int k;
        logic will_accept;
        k = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            alu_valid = 1'b1; alu_address = AW'(cyc); alu_data = {$urandom, $urandom};
            mem_valid = (k < 5); mem_address = AW'(16 + k); mem_data = {$urandom, $urandom};
            #1;
            n_cmp++; if (mem_ready !== model_ready()) begin n_bad++; $display("FAIL full_ready: got %0h want %0h", mem_ready, model_ready()); end
            will_accept = mem_valid && model_ready();
            clock_edge();
            if (will_accept) k++;
            n_cmp++; if (rf_address !== AW'(cyc)) begin n_bad++; $display("FAIL full_alu_addr: got %0d want %0d", rf_address, cyc); end
        end
        n_cmp++; if (pending !== 3'd4) begin n_bad++; $display("FAIL full_pending: got %0d want 4", pending); end
        n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL full_not_ready: got %0h want 0", mem_ready); end
        alu_valid = 1'b0;
        for (int d = 0; d < 5; d++) begin
            mem_valid = (k < 5); mem_address = AW'(16 + k); mem_data = {$urandom, $urandom};
            #1;
            n_cmp++; if (mem_ready !== model_ready()) begin n_bad++; $display("FAIL drain_ready: got %0h want %0h", mem_ready, model_ready()); end
            will_accept = mem_valid && model_ready();
            clock_edge();
            if (will_accept) k++;
            n_cmp++; if (rf_write !== 1'b1 || rf_address !== AW'(16 + d)) begin n_bad++; $display("FAIL drain_order: got %0h/%0d want 1/%0d", rf_write, rf_address, 16 + d); end
            n_cmp++; if (rf_data !== m_data) begin n_bad++; $display("FAIL drain_data: got %0h want %0h", rf_data, m_data); end
            n_cmp++; if (pending !== 3'(q_addr.size())) begin n_bad++; $display("FAIL drain_pending: got %0d want %0d", pending, q_addr.size()); end
        end
        idle();
        clock_edge();
    endtask

    task automatic test_zero_reg();
        idle();
        alu_valid = 1'b1; alu_address = 5'd31; alu_data = {$urandom, $urandom};
        clock_edge();
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++; $display("FAIL zero_alu: got %0h want 0", rf_write); end
        idle();
        mem_valid = 1'b1; mem_address = 5'd31; mem_data = {$urandom, $urandom};
        query_a = 5'd31;
        #1;
        n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready: got %0h want 1", mem_ready); end
        clock_edge();
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++; $display("FAIL zero_load_write: got %0h want 0", rf_write); end
        n_cmp++; if (pending !== 3'd0) begin n_bad++; $display("FAIL zero_load_pending: got %0d want 0", pending); end
        alu_valid = 1'b1; alu_address = 5'd4; alu_data = {$urandom, $urandom};
        clock_edge();
        n_cmp++; if (pending !== 3'd0) begin n_bad++; $display("FAIL zero_no_enqueue: got %0d want 0", pending); end
        n_cmp++; if (hazard_a !== 1'b0) begin n_bad++; $display("FAIL zero_hazard: got %0h want 0", hazard_a); end
        idle();
        clock_edge();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            alu_valid   = ($urandom_range(0, 9) < 5);
            alu_address = AW'($urandom_range(0, 31));
            alu_data    = {$urandom, $urandom};
            if (model_hazard(alu_address)) alu_valid = 1'b0;
            mem_valid   = ($urandom_range(0, 9) < 6);
            mem_address = AW'($urandom_range(0, 31));
            mem_data    = {$urandom, $urandom};
            if (model_hazard(mem_address) || (alu_valid && mem_address == alu_address)) mem_valid = 1'b0;
            query_a = AW'($urandom_range(0, 31));
            query_b = AW'($urandom_range(0, 31));
            #1;
            n_cmp++; if (mem_ready !== model_ready()) begin n_bad++; $display("FAIL rnd_ready: cyc %0d got %0h want %0h", cyc, mem_ready, model_ready()); end
            n_cmp++; if (hazard_a !== model_hazard(query_a)) begin n_bad++; $display("FAIL rnd_pre_hazard_a: cyc %0d got %0h want %0h", cyc, hazard_a, model_hazard(query_a)); end
            clock_edge();
            n_cmp++; if (rf_write !== m_write) begin n_bad++; $display("FAIL rnd_write: cyc %0d got %0h want %0h", cyc, rf_write, m_write); end
            n_cmp++; if (rf_address !== m_addr) begin n_bad++; $display("FAIL rnd_addr: cyc %0d got %0d want %0d", cyc, rf_address, m_addr); end
            n_cmp++; if (rf_data !== m_data) begin n_bad++; $display("FAIL rnd_data: cyc %0d got %0h want %0h", cyc, rf_data, m_data); end
            n_cmp++; if (pending !== 3'(q_addr.size())) begin n_bad++; $display("FAIL rnd_pending: cyc %0d got %0d want %0d", cyc, pending, q_addr.size()); end
            n_cmp++; if (hazard_a !== model_hazard(query_a)) begin n_bad++; $display("FAIL rnd_hazard_a: cyc %0d got %0h want %0h", cyc, hazard_a, model_hazard(query_a)); end
            n_cmp++; if (hazard_b !== model_hazard(query_b)) begin n_bad++; $display("FAIL rnd_hazard_b: cyc %0d got %0h want %0h", cyc, hazard_b, model_hazard(query_b)); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_collision();
        test_full_fifo();
        test_zero_reg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
